// File: rtl/multichannel_wave_capture.sv
// multichannel_wave_capture: NCH-channel circular-buffer capture with pre-trigger,
// level/external/software trigger and logical-index readout.
module multichannel_wave_capture #(
  parameter int NCH   = 2,
  parameter int DW    = 14,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = (NCH > 1 ? $clog2(NCH) : 1)
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [NCH*DW-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              ext_sel,
  input  logic              ext_trig,
  input  logic [CW-1:0]     trig_chan,
  input  logic              trig_slope,
  input  logic [DW-1:0]     trig_level,
  input  logic [AW-1:0]     pretrig,
  output logic              busy,
  output logic              done,
  output logic [15:0]       wave_num,
  output logic [AW-1:0]     start_addr,
  input  logic [CW-1:0]     rd_chan,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  state_t state;
  logic [AW-1:0] wp, cnt, pre_l, ra;
  logic [AW:0] post, total;
  logic [CW-1:0] chan_l;
  logic slope_l, ext_sel_l, ext_d, ext_pend, frc_pend, wr, hit, trig;
  logic [DW-1:0] level_l, prev, cur, rd_d;
  logic [DW-1:0] mem [NCH][DEPTH];

  assign busy  = state == PRE || state == WAIT || state == POST;
  assign done  = state == DONE;
  assign wr    = adc_valid && busy;
  assign total = (AW+1)'(DEPTH) - {1'b0, pre_l};
  assign ra    = start_addr + rd_addr;
  assign hit   = slope_l ? (prev > level_l && cur <= level_l) : (prev < level_l && cur >= level_l);
  assign trig  = adc_valid && state == WAIT && (frc_pend || (ext_sel_l ? ext_pend : hit));

  // out-of-range channel selects fall back to ch0
  always_comb begin
    cur  = adc_data[DW-1:0];
    rd_d = mem[0][ra];
    for (int c = 0; c < NCH; c++) begin
      if (chan_l == CW'(c)) cur = adc_data[c*DW +: DW];
      if (rd_chan == CW'(c)) rd_d = mem[c][ra];
    end
  end

  always_ff @(posedge sys_clk)
    if (wr)
      for (int c = 0; c < NCH; c++) mem[c][wp] <= adc_data[c*DW +: DW];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wp         <= '0;
      cnt        <= '0;
      post       <= '0;
      pre_l      <= '0;
      chan_l     <= '0;
      slope_l    <= 1'b0;
      ext_sel_l  <= 1'b0;
      level_l    <= '0;
      prev       <= '0;
      ext_d      <= 1'b0;
      ext_pend   <= 1'b0;
      frc_pend   <= 1'b0;
      wave_num   <= '0;
      start_addr <= '0;
      rd_data    <= '0;
    end else begin
      ext_d    <= ext_trig;
      rd_data  <= rd_d;
      if (adc_valid) prev <= cur;
      if (wr) wp <= wp + AW'(1);
      // pending requests live only in WAIT and are spent by the next sample
      ext_pend <= state == WAIT && ((ext_trig && !ext_d) || (ext_pend && !adc_valid));
      frc_pend <= state == WAIT && (force_trig || (frc_pend && !adc_valid));
      if (abort) state <= IDLE;
      else case (state)
        IDLE, DONE: if (arm) begin
          pre_l     <= pretrig;
          chan_l    <= trig_chan;
          slope_l   <= trig_slope;
          level_l   <= trig_level;
          ext_sel_l <= ext_sel;
          cnt       <= '0;
          state     <= pretrig == '0 ? WAIT : PRE;
        end
        PRE: if (adc_valid) begin
          cnt <= cnt + AW'(1);
          if (cnt + AW'(1) == pre_l) state <= WAIT;
        end
        WAIT: if (trig) begin
          start_addr <= wp - pre_l;
          post       <= (AW+1)'(1);
          if (pre_l == AW'(DEPTH-1)) begin
            state    <= DONE;
            wave_num <= wave_num + 16'd1;
          end else state <= POST;
        end
        POST: if (adc_valid) begin
          post <= post + (AW+1)'(1);
          if (post + (AW+1)'(1) == total) begin
            state    <= DONE;
            wave_num <= wave_num + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multichannel_wave_capture.sv
// tb_multichannel_wave_capture: random and directed captures checked against a
// sample-stream reference model.
module tb_multichannel_wave_capture;
  localparam int NCH = 2, DW = 14, DEPTH = 16, AW = 4, CW = 1;
  logic sys_clk = 0, reset_n = 0;
  logic [NCH*DW-1:0] adc_data = '0;
  logic adc_valid = 0, arm = 0, abort = 0, force_trig = 0, ext_sel = 0, ext_trig = 0;
  logic [CW-1:0] trig_chan = '0, rd_chan = '0;
  logic trig_slope = 0;
  logic [DW-1:0] trig_level = '0, rd_data;
  logic [AW-1:0] pretrig = '0, rd_addr = '0, start_addr;
  logic busy, done;
  logic [15:0] wave_num;

  multichannel_wave_capture #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .abort(abort), .force_trig(force_trig), .ext_sel(ext_sel), .ext_trig(ext_trig),
    .trig_chan(trig_chan), .trig_slope(trig_slope), .trig_level(trig_level), .pretrig(pretrig),
    .busy(busy), .done(done), .wave_num(wave_num), .start_addr(start_addr),
    .rd_chan(rd_chan), .rd_addr(rd_addr), .rd_data(rd_data));

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] sq0[$], sq1[$];
  logic [DW-1:0] tbl [5] = '{9380, 9390, 9395, 9405, 9410};
  logic [DW-1:0] prev_m = '0, lv_m = '0;
  logic chan_m = 0, sl_m = 0, es_m = 0, ep = 0, fp = 0, e_prev = 0;
  logic cap_m = 0, trg_m = 0, done_m = 0;
  int pt_m = 0, tk = 0, wp_m = 0, wn_m = 0, start_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock cycle of stimulus; the model follows the stream of written samples
  task automatic step(input logic v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic e, input logic f, input logic a, input logic ab);
    logic [DW-1:0] cur;
    logic in_wait, hit, tg, cap0;
    adc_valid = v; adc_data = {d1, d0}; ext_trig = e; force_trig = f; arm = a; abort = ab;
    cur = chan_m ? d1 : d0;
    cap0 = cap_m;
    in_wait = cap_m && !trg_m && sq0.size() >= pt_m;
    if (ab) begin
      cap_m = 0; done_m = 0; ep = 0; fp = 0;
    end else if (cap_m && v) begin
      sq0.push_back(d0); sq1.push_back(d1);
      if (in_wait) begin
        hit = sl_m ? (prev_m > lv_m && cur <= lv_m) : (prev_m < lv_m && cur >= lv_m);
        tg = fp || (es_m ? ep : hit);
        ep = 0; fp = 0;
        if (tg) begin
          trg_m = 1; tk = sq0.size() - 1; start_m = (wp_m + DEPTH - pt_m) % DEPTH;
        end
      end
      wp_m = (wp_m + 1) % DEPTH;
      if (trg_m && sq0.size() == tk + DEPTH - pt_m) begin
        cap_m = 0; done_m = 1; wn_m = (wn_m + 1) % 65536;
      end
    end
    if (!ab && in_wait && !trg_m) begin
      if (e && !e_prev) ep = 1;
      if (f) fp = 1;
    end
    if (v) prev_m = cur;
    if (a && !ab && !cap0) begin
      pt_m = int'(pretrig); chan_m = trig_chan; sl_m = trig_slope; lv_m = trig_level; es_m = ext_sel;
      cap_m = 1; trg_m = 0; done_m = 0; sq0.delete(); sq1.delete();
    end
    e_prev = e;
    @(posedge sys_clk); #1;
    chk("busy", busy, cap_m);
    chk("done", done, done_m);
    arm = 0; abort = 0; force_trig = 0; adc_valid = 0;
  endtask

  task automatic rd(input logic ch, input int a, input logic [DW-1:0] exp, input string tag);
    rd_chan = ch; rd_addr = AW'(a);
    @(posedge sys_clk); #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic verify();
    chk("done_end", done, 1);
    chk("wave_num", wave_num, wn_m);
    chk("start_addr", start_addr, start_m);
    for (int i = 0; i < DEPTH; i++) begin
      rd(0, i, sq0[tk - pt_m + i], "rd_ch0");
      rd(1, i, sq1[tk - pt_m + i], "rd_ch1");
    end
  endtask

  task automatic capture(input int mode, input logic [AW-1:0] pt, input logic ch, input logic sl,
                         input logic [DW-1:0] lv, input logic es, input int stop);
    logic v, e, f;
    logic [DW-1:0] d0, d1;
    pretrig = pt; trig_chan = ch; trig_slope = sl; trig_level = lv; ext_sel = es;
    step(0, '0, '0, e_prev, 0, 1, 0);
    for (int s = 0; cap_m && s < 300 && (stop == 0 || s < stop); s++) begin
      v = 1; e = 0; f = 0;
      d0 = DW'($urandom_range(0, 16383)); d1 = DW'($urandom_range(0, 16383));
      if (mode == 0) d1 = DW'(6975 + 5 * s);
      else if (mode == 1) d0 = s < 5 ? tbl[s] : DW'(9410 - 5 * (s - 4));
      else if (mode == 2) begin
        v = $urandom_range(0, 3) != 0;
        d0 = DW'(int'(lv) - 20 + $urandom_range(0, 40));
        d1 = DW'(int'(lv) - 20 + $urandom_range(0, 40));
        e = $urandom_range(0, 7) == 0;
        f = $urandom_range(0, 15) == 0;
      end else begin
        d0 = 1000; d1 = 1000;
        e = mode == 3 && (s == 1 || s == int'(pt) + 4);
        f = mode == 4 && s == int'(pt) + 3;
      end
      step(v, d0, d1, e, f, 0, 0);
    end
    if (stop == 0) begin
      chk("complete", cap_m, 0);
      if (!cap_m) verify();
    end
  endtask

  task automatic do_reset();
    reset_n = 0; ext_trig = 0; #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wave_num", wave_num, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_start_addr", start_addr, 0);
    cap_m = 0; trg_m = 0; done_m = 0; wn_m = 0; wp_m = 0; prev_m = 0; chan_m = 0;
    ep = 0; fp = 0; e_prev = 0; start_m = 0;
    @(posedge sys_clk); #1;
    reset_n = 1;
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    do_reset();
    capture(0, 4, 1, 0, 7000, 0, 0);
    rd(1, 3, 6995, "t1_addr3");
    rd(1, 4, 7000, "t1_addr4");
    rd(1, 15, 7055, "t1_addr15");
    chk("t1_wave_num", wave_num, 1);
    capture(1, 4, 0, 1, 9400, 0, 0);
    rd(0, 4, 9400, "t2_trig_sample");
    capture(2, 0, 0, 0, DW'(5000), 0, 0);
    capture(2, 15, 1, 1, DW'(6000), 0, 0);
    capture(3, 4, 0, 0, 9000, 1, 0);
    capture(4, 4, 1, 0, 9000, 0, 0);
    for (int i = 0; i < 8; i++)
      capture(2, AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              DW'(2000 + $urandom_range(0, 8000)), 1'($urandom_range(0, 1)), 0);
    capture(5, 2, 0, 0, 9000, 0, 6);
    step(1, 1000, 1000, 0, 0, 1, 1);
    chk("abort_wave_num", wave_num, wn_m);
    chk("abort_start_addr", start_addr, start_m);
    capture(0, 4, 1, 0, 7000, 0, 9);
    do_reset();
    capture(2, 3, 0, 0, DW'(4000), 0, 0);
    chk("post_reset_wave_num", wave_num, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
